// File: rtl/player_lives_counter_pkg.sv
// Shared game parameters: lives display constants, lives/invulnerability
// defaults and the player state enum.
package player_lives_counter_pkg;

  // Lives icon display placement (pixels)
  localparam int unsigned LIVES_ICON_WIDTH  = 16;
  localparam int unsigned LIVES_ICON_HEIGHT = 16;
  localparam int unsigned LIVES_ICON_GAP    = 4;
  localparam int unsigned LIVES_ICON_X0     = 8;
  localparam int unsigned LIVES_ICON_Y0     = 8;

  // Player lives and post-hit invulnerability
  localparam int unsigned PLAYER_LIVES_AMOUNT       = 3;
  localparam int unsigned PLAYER_LIVES_AMOUNT_WIDTH = 2;
  localparam int unsigned INVULN_FRAMES             = 90;
  localparam int unsigned BLINK_SHIFT               = 3;

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    INVULN    = 2'd1,
    GAME_OVER = 2'd2
  } player_state_e;

  // Width of a down-counter that must hold the value `frames`
  function automatic int unsigned timer_width(input int unsigned frames);
    return $clog2(frames + 1);
  endfunction

endpackage

// File: rtl/player_lives_counter_frame_down_counter.sv
// Loadable frame down-counter: decrements once per enabled frame, stops at
// zero, flags the last frame of the count (count == 1).
module frame_down_counter #(
  parameter int unsigned WIDTH   = 7,
  parameter int unsigned TAP_BIT = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             enable_i,
  output logic             tc_o,
  output logic             tap_next_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: clear beats load, load beats a same-cycle decrement
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_value_i;
    end else if (enable_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o       = (count_q == WIDTH'(1));
  // Tap taken from the next count so a downstream register lines up with count_q
  assign tap_next_o = count_d[TAP_BIT];

endmodule

// File: rtl/player_lives_counter.sv
// Player lives counter: lives register, ALIVE/INVULN/GAME_OVER FSM,
// invulnerability window timing and registered status outputs.
module player_lives_counter #(
  parameter int unsigned PLAYER_LIVES_AMOUNT       = player_lives_counter_pkg::PLAYER_LIVES_AMOUNT,
  parameter int unsigned PLAYER_LIVES_AMOUNT_WIDTH = player_lives_counter_pkg::PLAYER_LIVES_AMOUNT_WIDTH,
  parameter int unsigned INVULN_FRAMES             = player_lives_counter_pkg::INVULN_FRAMES,
  parameter int unsigned BLINK_SHIFT               = player_lives_counter_pkg::BLINK_SHIFT
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 startOfFrame,
  input  logic                                 new_game,
  input  logic                                 player_hit,
  input  logic                                 extra_life,
  output logic [PLAYER_LIVES_AMOUNT_WIDTH-1:0] remaining_lives,
  output logic                                 invulnerable,
  output logic                                 player_visible,
  output logic                                 player_died,
  output logic                                 game_over
);

  import player_lives_counter_pkg::*;

  localparam int unsigned TIMER_W = timer_width(INVULN_FRAMES);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(INVULN_FRAMES);
  localparam logic [PLAYER_LIVES_AMOUNT_WIDTH-1:0] LIVES_MAX =
    PLAYER_LIVES_AMOUNT_WIDTH'(PLAYER_LIVES_AMOUNT);
  localparam logic [PLAYER_LIVES_AMOUNT_WIDTH-1:0] LIVES_ONE =
    PLAYER_LIVES_AMOUNT_WIDTH'(1);

  player_state_e state_q, state_d;
  logic [PLAYER_LIVES_AMOUNT_WIDTH-1:0] lives_q, lives_d, lives_inc;
  logic died_q, died_d;
  logic invuln_q, invuln_d;
  logic visible_q, visible_d;
  logic over_q, over_d;
  logic timer_load;
  logic timer_tc;
  logic timer_tap_next;

  frame_down_counter #(
    .WIDTH   (TIMER_W),
    .TAP_BIT (BLINK_SHIFT)
  ) u_window_timer (
    .clk_i        (clk),
    .reset_i      (reset),
    .clear_i      (new_game),
    .load_i       (timer_load),
    .load_value_i (TIMER_LOAD),
    .enable_i     (startOfFrame),
    .tc_o         (timer_tc),
    .tap_next_o   (timer_tap_next)
  );

  // Bonus life, saturating at the starting amount
  always_comb begin
    lives_inc = (lives_q >= LIVES_MAX) ? LIVES_MAX : (lives_q + LIVES_ONE);
  end

  // Next state, lives update and timer load
  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    died_d     = 1'b0;
    timer_load = 1'b0;
    unique case (state_q)
      ALIVE: begin
        if (player_hit) begin
          died_d = 1'b1;
          if (extra_life) begin
            // Bonus cancels the loss: lives unchanged, never game over
            state_d    = INVULN;
            timer_load = 1'b1;
          end else if (lives_q > LIVES_ONE) begin
            lives_d    = lives_q - LIVES_ONE;
            state_d    = INVULN;
            timer_load = 1'b1;
          end else begin
            lives_d = '0;
            state_d = GAME_OVER;
          end
        end else if (extra_life) begin
          lives_d = lives_inc;
        end
      end
      INVULN: begin
        if (extra_life) begin
          lives_d = lives_inc;
        end
        if (startOfFrame && timer_tc) begin
          state_d = ALIVE;
        end
      end
      GAME_OVER: begin
        state_d = GAME_OVER;
      end
      default: begin
        state_d = ALIVE;
      end
    endcase
  end

  // Status outputs decoded from the next state so they register with it
  always_comb begin
    invuln_d  = (state_d == INVULN);
    over_d    = (state_d == GAME_OVER);
    visible_d = 1'b1;
    unique case (state_d)
      INVULN:    visible_d = timer_tap_next;
      GAME_OVER: visible_d = 1'b0;
      default:   visible_d = 1'b1;
    endcase
  end

  // State, lives and output registers; new_game restarts like reset
  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      state_q   <= ALIVE;
      lives_q   <= LIVES_MAX;
      died_q    <= 1'b0;
      invuln_q  <= 1'b0;
      visible_q <= 1'b1;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      died_q    <= died_d;
      invuln_q  <= invuln_d;
      visible_q <= visible_d;
      over_q    <= over_d;
    end
  end

  assign remaining_lives = lives_q;
  assign invulnerable    = invuln_q;
  assign player_visible  = visible_q;
  assign player_died     = died_q;
  assign game_over       = over_q;

endmodule

// File: tb/tb_player_lives_counter.sv
// Self-checking bench for player_lives_counter: directed scenarios followed
// by random stimulus, every cycle compared with a behavioural lives model.
module tb_player_lives_counter;

  localparam int P_LIVES = 3;
  localparam int P_INV   = 90;
  localparam int P_BLINK = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       new_game = 1'b0;
  logic       player_hit = 1'b0;
  logic       extra_life = 1'b0;
  logic [1:0] remaining_lives;
  logic       invulnerable;
  logic       player_visible;
  logic       player_died;
  logic       game_over;

  int checks = 0;
  int errors = 0;
  int died_cnt = 0;

  // Reference model
  int m_lives = 0;
  int m_frames = 0;
  bit m_win = 0;
  bit m_over = 0;
  bit m_died = 0;

  player_lives_counter #(
    .PLAYER_LIVES_AMOUNT       (P_LIVES),
    .PLAYER_LIVES_AMOUNT_WIDTH (2),
    .INVULN_FRAMES             (P_INV),
    .BLINK_SHIFT               (P_BLINK)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .startOfFrame    (startOfFrame),
    .new_game        (new_game),
    .player_hit      (player_hit),
    .extra_life      (extra_life),
    .remaining_lives (remaining_lives),
    .invulnerable    (invulnerable),
    .player_visible  (player_visible),
    .player_died     (player_died),
    .game_over       (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare every output
  task automatic step(input bit h, input bit s, input bit e, input bit n, input bit r);
    int exp_vis;
    player_hit   = h;
    startOfFrame = s;
    extra_life   = e;
    new_game     = n;
    reset        = r;
    @(posedge clk);
    #1;
    m_died = 0;
    if (r || n) begin
      m_lives = P_LIVES; m_win = 0; m_over = 0; m_frames = 0;
    end else if (m_over) begin
      // nothing but a restart leaves game over
    end else if (m_win) begin
      if (e && m_lives < P_LIVES) m_lives++;
      if (s) begin
        m_frames--;
        if (m_frames == 0) m_win = 0;
      end
    end else if (h) begin
      m_died = 1;
      if (!e) m_lives--;
      if (m_lives == 0) m_over = 1;
      else begin
        m_win = 1; m_frames = P_INV;
      end
    end else if (e && m_lives < P_LIVES) begin
      m_lives++;
    end
    exp_vis = m_over ? 0 : (m_win ? ((m_frames >> P_BLINK) & 1) : 1);
    chk("lives",   remaining_lives, m_lives);
    chk("invuln",  invulnerable, m_win);
    chk("visible", player_visible, exp_vis);
    chk("died",    player_died, m_died);
    chk("over",    game_over, m_over);
    if (player_died === 1'b1) died_cnt++;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0);
  endtask

  initial begin
    bit hit_lvl;
    hit_lvl = 0;

    // Reset state
    step(0, 0, 0, 0, 1);
    chk("rst_lives", remaining_lives, 3);
    chk("rst_vis", player_visible, 1);

    // Hit held for 50 cycles gives exactly one death
    died_cnt = 0;
    repeat (50) step(1, 0, 0, 0, 0);
    chk("hold_pulses", died_cnt, 1);
    chk("hold_lives", remaining_lives, 2);
    chk("hold_inv", invulnerable, 1);

    // Window length
    frames(89);
    chk("win89_inv", invulnerable, 1);
    frames(1);
    chk("win90_inv", invulnerable, 0);
    chk("win90_vis", player_visible, 1);

    // Three hits to game over
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0); frames(P_INV);
    chk("h1_lives", remaining_lives, 2);
    step(1, 0, 0, 0, 0); frames(P_INV);
    chk("h2_lives", remaining_lives, 1);
    step(1, 0, 0, 0, 0);
    chk("h3_lives", remaining_lives, 0);
    chk("h3_over", game_over, 1);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("go_lives", remaining_lives, 0);
    chk("go_over", game_over, 1);

    // Hit with extra life at one life
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0); frames(P_INV);
    step(1, 0, 0, 0, 0); frames(P_INV);
    chk("one_lives", remaining_lives, 1);
    died_cnt = 0;
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("he_lives", remaining_lives, 1);
    chk("he_inv", invulnerable, 1);
    chk("he_over", game_over, 0);
    chk("he_pulses", died_cnt, 1);

    // Saturation
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    chk("sat_lives", remaining_lives, 3);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("sat_inv_lives", remaining_lives, 3);
    chk("sat_inv", invulnerable, 1);

    // new_game mid-window
    frames(5);
    step(0, 0, 0, 1, 0);
    chk("ngw_lives", remaining_lives, 3);
    chk("ngw_inv", invulnerable, 0);
    chk("ngw_vis", player_visible, 1);

    // new_game from game over
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0); frames(P_INV);
    end
    chk("ngo_pre", game_over, 1);
    step(0, 0, 0, 1, 0);
    chk("ngo_over", game_over, 0);
    chk("ngo_lives", remaining_lives, 3);

    // Reset mid-window
    step(1, 0, 0, 0, 0); frames(10);
    step(0, 1, 0, 0, 1);
    chk("rsw_lives", remaining_lives, 3);
    chk("rsw_inv", invulnerable, 0);
    chk("rsw_vis", player_visible, 1);

    // Frame pulse coinciding with the hit does not shorten the window
    step(1, 1, 0, 0, 0); frames(89);
    chk("sof_hit_89", invulnerable, 1);
    frames(1);
    chk("sof_hit_90", invulnerable, 0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) hit_lvl = ~hit_lvl;
      step(hit_lvl,
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 799) == 0),
           ($urandom_range(0, 1499) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
